// File: rtl/window_scanner.sv
// Walks a WIN x WIN window across a loaded IMG x IMG byte tile in raster order.
// Each window is registered and offered under valid/ready; a done pulse ends the tile.
module window_scanner #(
  parameter int IMG    = 16,
  parameter int WIN    = 4,
  parameter int STRIDE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               img_in  [0:IMG-1][0:IMG-1],
  output logic [7:0]               win_out [0:WIN-1][0:WIN-1],
  output logic [$clog2(IMG)-1:0]   win_row,
  output logic [$clog2(IMG)-1:0]   win_col,
  output logic                     valid,
  input  logic                     ready,
  output logic                     busy,
  output logic                     done
);

  localparam int PW = $clog2(IMG);
  localparam int P  = (IMG - WIN) / STRIDE + 1;
  localparam logic [PW-1:0] LAST = PW'((P - 1) * STRIDE);
  localparam logic [PW-1:0] STEP = PW'(STRIDE);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] row_q, row_d, col_q, col_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [7:0]    win_q [0:WIN-1][0:WIN-1];
  logic [7:0]    win_d [0:WIN-1][0:WIN-1];
  logic          load;
  logic          xfer;
  logic          last;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    xfer    = valid_q & ready;
    last    = (row_q == LAST) && (col_q == LAST);

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = SCAN;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      SCAN: begin
        if (xfer) begin
          if (last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + STEP;
            end else begin
              col_d = col_q + STEP;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The slice is taken at the *next* origin so the new window lands on the transfer edge.
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        win_d[i][j] = load ? img_in[row_d + PW'(i)][col_d + PW'(j)] : win_q[i][j];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the window is a small flop array, not a RAM, so clearing it on reset is cheap and intended.
      win_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign win_out = win_q;
  assign win_row = row_q;
  assign win_col = col_q;
  assign valid   = valid_q;
  assign busy    = (state_q == SCAN);
  assign done    = done_q;

endmodule

// File: tb/tb_window_scanner.sv
// Directed self-checking bench for window_scanner: default STRIDE=1 instance and a STRIDE=4 instance.
// Tile content is img[r][c] = 16*r + c, so every expected byte is computable by hand.
module tb_window_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] img [0:15][0:15];

  logic       start, ready, valid, busy, done;
  logic [7:0] win_out [0:3][0:3];
  logic [3:0] win_row, win_col;

  logic       s4_start, s4_ready, s4_valid, s4_busy, s4_done;
  logic [7:0] s4_win [0:3][0:3];
  logic [3:0] s4_row, s4_col;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  window_scanner dut (
    .clock(clock), .reset(reset), .start(start), .img_in(img),
    .win_out(win_out), .win_row(win_row), .win_col(win_col),
    .valid(valid), .ready(ready), .busy(busy), .done(done)
  );

  window_scanner #(.STRIDE(4)) dut_s4 (
    .clock(clock), .reset(reset), .start(s4_start), .img_in(img),
    .win_out(s4_win), .win_row(s4_row), .win_col(s4_col),
    .valid(s4_valid), .ready(s4_ready), .busy(s4_busy), .done(s4_done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] pack_win(input logic [7:0] w [0:3][0:3]);
    logic [127:0] v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        v[127 - 8*(4*i + j) -: 8] = w[i][j];
    return v;
  endfunction

  function automatic logic [127:0] exp_win(input int r, input int c);
    logic [127:0] v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        v[127 - 8*(4*i + j) -: 8] = 8'(16*(r + i) + (c + j));
    return v;
  endfunction

  // Drives one scan on the STRIDE=1 instance, checking every presented window against the
  // raster model. Stops at done, or right after a planted reset at window abort_win.
  task automatic run_scan(input int bp_win, input int start_win, input int abort_win,
                          input bit hold_start, output int n_win, output int n_done,
                          output int done_cyc, output int bp_seen);
    int idx, bp_cnt, er, ec;
    bit fin;
    n_win = 0; n_done = 0; done_cyc = 0; bp_seen = 0; bp_cnt = 0; fin = 1'b0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("done_cycle_idle", {busy, valid}, 2'b00);
        fin = 1'b1;
      end else if (valid) begin
        idx = n_win + 1;
        er  = (idx - 1) / 13;
        ec  = (idx - 1) % 13;
        check("origin", {win_row, win_col, busy}, {4'(er), 4'(ec), 1'b1});
        check("window", pack_win(win_out), exp_win(er, ec));
        if (idx == 1)   check("w1_w33", win_out[3][3], 8'h33);
        if (idx == 2)   check("w2_w00", win_out[0][0], 8'h01);
        if (idx == 14)  check("w14_origin", {win_row, win_col, win_out[0][0]}, {4'd1, 4'd0, 8'h10});
        if (idx == 169) check("w169_last", {win_row, win_col, win_out[3][3]}, {4'd12, 4'd12, 8'hFF});
        if (idx == abort_win) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          check("abort_flags", {valid, busy, done}, 3'b000);
          check("abort_origin", {win_row, win_col}, 8'h00);
          check("abort_win", pack_win(win_out), 128'h0);
          for (int k = 0; k < 3; k++) begin
            step();
            n_done += int'(done);
          end
          return;
        end
        if (idx == bp_win && bp_cnt < 5) begin
          ready = 1'b0;
          bp_cnt++;
        end else begin
          ready = 1'b1;
        end
        if (idx == bp_win) bp_seen++;
        start = hold_start || (idx == start_win);
        if (ready) n_win++;
        step();
      end else begin
        check("valid_during_scan", valid, 1'b1);
        step();
      end
    end
  endtask

  int nw, nd, dc, bs, k4, d4;

  initial begin
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = 8'(16*r + c);

    // Reset asserted together with start: reset must win.
    reset = 1'b1; start = 1'b1; ready = 1'b1; s4_start = 1'b1; s4_ready = 1'b1;
    step(); step();
    check("rst_flags", {valid, busy, done}, 3'b000);
    check("rst_origin", {win_row, win_col}, 8'h00);
    check("rst_win", pack_win(win_out), 128'h0);
    check("rst_s4_flags", {s4_valid, s4_busy, s4_done}, 3'b000);
    reset = 1'b0; start = 1'b0; s4_start = 1'b0;
    step();
    check("idle_no_start", {valid, busy, done}, 3'b000);

    // Plain scan with ready held high.
    start = 1'b1; step();
    run_scan(-1, -1, -1, 1'b0, nw, nd, dc, bs);
    check("plain_windows", nw, 169);
    check("plain_done_cnt", nd, 1);
    check("plain_done_cyc", dc, 170);
    step();
    check("done_one_cycle", {done, valid, busy}, 3'b000);
    check("hold_after_done", {win_row, win_col, win_out[3][3]}, {4'd12, 4'd12, 8'hFF});

    // Backpressure on origin (0,2).
    start = 1'b1; step();
    run_scan(3, -1, -1, 1'b0, nw, nd, dc, bs);
    check("bp_cycles_shown", bs, 6);
    check("bp_windows", nw, 169);
    check("bp_done_cyc", dc, 175);
    step();

    // start during SCAN is ignored.
    start = 1'b1; step();
    run_scan(-1, 40, -1, 1'b0, nw, nd, dc, bs);
    check("restart_windows", nw, 169);
    check("restart_done_cnt", nd, 1);
    check("restart_done_cyc", dc, 170);
    step();

    // Reset mid-scan, then a fresh scan from (0,0).
    start = 1'b1; step();
    run_scan(-1, -1, 50, 1'b0, nw, nd, dc, bs);
    check("abort_windows", nw, 49);
    check("abort_no_done", nd, 0);
    start = 1'b1; step();
    run_scan(-1, -1, -1, 1'b0, nw, nd, dc, bs);
    check("after_abort_windows", nw, 169);
    check("after_abort_done_cyc", dc, 170);
    step();

    // start held high: second scan begins in the done cycle.
    start = 1'b1; step();
    run_scan(-1, -1, -1, 1'b1, nw, nd, dc, bs);
    check("hold_done_cyc", dc, 170);
    step();
    check("b2b_first", {valid, busy, done, win_row, win_col}, {3'b110, 8'h00});
    check("b2b_win", pack_win(win_out), exp_win(0, 0));
    start = 1'b0; reset = 1'b1; step();
    reset = 1'b0; step();

    // STRIDE=4 instance.
    k4 = 0; d4 = 0;
    s4_start = 1'b1; step();
    s4_start = 1'b0;
    for (int cyc = 1; cyc <= 40 && d4 == 0; cyc++) begin
      if (s4_done) begin
        d4 = cyc;
      end else begin
        if (s4_valid) begin
          k4++;
          check("s4_origin", {s4_row, s4_col}, {4'(4*((k4-1)/4)), 4'(4*((k4-1)%4))});
          check("s4_window", pack_win(s4_win), exp_win(4*((k4-1)/4), 4*((k4-1)%4)));
          if (k4 == 2)  check("s4_w2", {s4_row, s4_col, s4_win[0][0]}, {4'd0, 4'd4, 8'h04});
          if (k4 == 5)  check("s4_w5", {s4_row, s4_col, s4_win[0][0]}, {4'd4, 4'd0, 8'h40});
          if (k4 == 16) check("s4_last", {s4_row, s4_col, s4_win[3][3]}, {4'd12, 4'd12, 8'hFF});
        end
        step();
      end
    end
    check("s4_windows", k4, 16);
    check("s4_done_cyc", d4, 17);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
